// File: rtl/system_sw_debounce_ctrl.sv
// rtl/system_sw_debounce_ctrl.sv - slide-switch sync, debounce, edge capture and irq behind an Avalon-MM slave
module system_sw_debounce_ctrl #(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         sync1_q, sync1_d;
  logic [WIDTH-1:0]         sync2_q, sync2_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic [WIDTH-1:0]         data_dly_q, data_dly_d;
  logic [WIDTH-1:0]         edgecap_q, edgecap_d;
  logic [WIDTH-1:0]         irqmask_q, irqmask_d;
  logic [2:0]               ctrl_q, ctrl_d;
  logic [15:0]              evcnt_q, evcnt_d;
  logic [31:0]              readdata_q, readdata_d;
  logic                     irq_q, irq_d;

  logic                     wr_en, rd_en, tick, any_set;
  logic [WIDTH-1:0]         edge_set, w1c;
  logic                     unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    wr_en = chipselect & write;
    rd_en = chipselect & read;
    tick  = ctrl_q[0] && (presc_q == PRESC_MAX);

    sync1_d = in_port;
    sync2_d = sync1_q;

    if (!ctrl_q[0] || tick) presc_d = '0;
    else                    presc_d = presc_q + PW'(1);

    data_d = data_q;
    cnt_d  = cnt_q;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == data_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= CNT_MAX) begin
          data_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    // Edges are detected against a delayed copy so capture lands the cycle after DATA moves
    data_dly_d = data_q;
    edge_set   = (data_q & ~data_dly_q & {WIDTH{ctrl_q[1]}})
               | (~data_q & data_dly_q & {WIDTH{ctrl_q[2]}});
    any_set    = |edge_set;

    w1c = '0;
    if (wr_en && address == 3'd3) w1c = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~w1c) | edge_set;

    irqmask_d = irqmask_q;
    if (wr_en && address == 3'd2) irqmask_d = writedata[WIDTH-1:0];

    ctrl_d = ctrl_q;
    if (wr_en && address == 3'd4) ctrl_d = writedata[2:0];

    evcnt_d = evcnt_q;
    if (wr_en && address == 3'd5)            evcnt_d = any_set ? 16'd1 : 16'd0;
    else if (any_set && evcnt_q != 16'hFFFF) evcnt_d = evcnt_q + 16'd1;

    irq_d = |(edgecap_q & irqmask_q);

    readdata_d = '0;
    if (rd_en) begin
      case (address)
        3'd0:    readdata_d[WIDTH-1:0] = data_q;
        3'd1:    readdata_d[WIDTH-1:0] = sync2_q;
        3'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
        3'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
        3'd4:    readdata_d[2:0]       = ctrl_q;
        3'd5:    readdata_d[15:0]      = evcnt_q;
        default: readdata_d            = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      data_dly_q <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      ctrl_q     <= 3'b011;
      evcnt_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      data_dly_q <= data_dly_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      ctrl_q     <= ctrl_d;
      evcnt_q    <= evcnt_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_system_sw_debounce_ctrl.sv
// tb/tb_system_sw_debounce_ctrl.sv - directed bench for system_sw_debounce_ctrl (WIDTH=10, TICK_DIV=4, STABLE_TICKS=3)
module tb_system_sw_debounce_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, rd, wr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  in_port;
  logic        irq;
  logic [31:0] rv;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  system_sw_debounce_ctrl #(.WIDTH(10), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(rd), .write(wr), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; rd = 1'b1; address = a;
    step();
    chipselect = 1'b0; rd = 1'b0;
    d = readdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] dat);
    chipselect = 1'b1; wr = 1'b1; address = a; writedata = dat;
    step();
    chipselect = 1'b0; wr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    chipselect = 1'b0; rd = 1'b0; wr = 1'b0; address = '0; writedata = '0;

    // 1/2: reset values, then bit0 settles after three ticks
    in_port = 10'h001;
    do_reset();
    bus_read(3'd4, rv); chk("rst_ctrl", rv, 32'h3);
    bus_read(3'd0, rv); chk("rst_data", rv, 32'h0);
    bus_read(3'd2, rv); chk("rst_mask", rv, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    step(7);
    bus_read(3'd0, rv); chk("data_before_3rd_tick", rv, 32'h0);
    step(1);
    bus_read(3'd0, rv); chk("data_after_3rd_tick", rv, 32'h001);
    bus_read(3'd3, rv); chk("edgecap_rise", rv, 32'h001);
    bus_read(3'd5, rv); chk("evcnt_one", rv, 32'h1);
    bus_read(3'd6, rv); chk("addr6_zero", rv, 32'h0);
    bus_read(3'd1, rv); chk("raw_level", rv, 32'h001);

    // 3: two-tick glitch is rejected
    in_port = 10'h000;
    do_reset();
    in_port = 10'h001;
    step(8);
    in_port = 10'h000;
    step(8);
    bus_read(3'd0, rv); chk("glitch_data", rv, 32'h0);
    bus_read(3'd3, rv); chk("glitch_edgecap", rv, 32'h0);
    bus_read(3'd5, rv); chk("glitch_evcnt", rv, 32'h0);

    // 4: irq, W1C, set-wins, read-during-write
    in_port = 10'h001;
    do_reset();
    bus_write(3'd2, 32'h001);
    step(12);
    chk("irq_not_yet", {31'b0, irq}, 32'h0);
    step(1);
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h001);
    chk("irq_still_set", {31'b0, irq}, 32'h1);
    step(1);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(3'd3, rv); chk("edgecap_w1c", rv, 32'h0);
    in_port = 10'h000;
    bus_write(3'd4, 32'h7);
    step(10);
    bus_write(3'd3, 32'h001);
    bus_read(3'd3, rv); chk("edgecap_set_wins", rv, 32'h001);
    bus_read(3'd5, rv); chk("evcnt_two", rv, 32'h2);
    chipselect = 1'b1; rd = 1'b1; wr = 1'b1; address = 3'd2; writedata = 32'h3FF;
    step();
    chipselect = 1'b0; rd = 1'b0; wr = 1'b0;
    chk("rw_prewrite", readdata, 32'h001);
    bus_read(3'd2, rv); chk("mask_written", rv, 32'h3FF);

    // 5: fall-only capture, then EN=0 freezes DATA
    in_port = 10'h3FF;
    do_reset();
    bus_write(3'd4, 32'h5);
    step(12);
    bus_read(3'd3, rv); chk("no_rise_capture", rv, 32'h0);
    bus_read(3'd0, rv); chk("data_all_high", rv, 32'h3FF);
    in_port = 10'h000;
    step(14);
    bus_read(3'd3, rv); chk("fall_capture", rv, 32'h3FF);
    bus_read(3'd5, rv); chk("fall_evcnt", rv, 32'h1);
    bus_write(3'd4, 32'h0);
    in_port = 10'h155;
    step(30);
    bus_read(3'd0, rv); chk("frozen_data", rv, 32'h0);
    bus_read(3'd1, rv); chk("frozen_raw", rv, 32'h155);

    // 6: clear coinciding with an event, counting, saturation, clear
    in_port = 10'h001;
    do_reset();
    step(12);
    bus_write(3'd5, 32'h0);
    bus_read(3'd5, rv); chk("clear_with_event", rv, 32'h1);
    bus_write(3'd4, 32'h7);
    for (int k = 0; k < 6; k++) begin
      in_port = (k % 2 == 0) ? 10'h3FF : 10'h000;
      step(20);
    end
    bus_read(3'd5, rv); chk("evcnt_seven", rv, 32'h7);
    force dut.evcnt_q = 16'hFFFE;
    #1;
    release dut.evcnt_q;
    for (int k = 0; k < 2; k++) begin
      in_port = (k == 0) ? 10'h3FF : 10'h000;
      step(20);
    end
    bus_read(3'd5, rv); chk("evcnt_saturate", rv, 32'hFFFF);
    bus_write(3'd5, 32'h1234);
    bus_read(3'd5, rv); chk("evcnt_cleared", rv, 32'h0);

    // reset while bit0 is two ticks into its debounce
    in_port = 10'h001;
    step(10);
    do_reset();
    bus_read(3'd0, rv); chk("midrst_data", rv, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    step(9);
    bus_read(3'd0, rv); chk("midrst_cnt_restart", rv, 32'h0);
    step(1);
    bus_read(3'd0, rv); chk("midrst_settled", rv, 32'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
